// File: rtl/design_switcher.sv
// design_switcher: synchronised, debounced design select with guarded hand-over of the GPIO pads.
module design_switcher #(
  parameter int NUM_DESIGNS   = 12,
  parameter int GPIO_WIDTH    = 34,
  parameter int STABLE_CYCLES = 4,
  parameter int GUARD_CYCLES  = 8,
  parameter int SEL_WIDTH     = $clog2(NUM_DESIGNS + 1)
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [SEL_WIDTH-1:0]              design_select,
  input  logic [NUM_DESIGNS*GPIO_WIDTH-1:0] designs_gpio_out,
  input  logic [NUM_DESIGNS*GPIO_WIDTH-1:0] designs_gpio_oeb,
  output logic [GPIO_WIDTH-1:0]             gpio_out,
  output logic [GPIO_WIDTH-1:0]             gpio_oeb,
  output logic [NUM_DESIGNS-1:0]            designs_ncs,
  output logic [SEL_WIDTH-1:0]              active_design,
  output logic                              switching
);
  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_e;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [7:0] GLAST  = 8'(GUARD_CYCLES - 1);
  state_e state_q, state_d;
  logic [SEL_WIDTH-1:0] s1_q, s2_q, cand_q, target_q, target_d, active_q, active_d, req;
  logic [7:0] cnt_q, cnt_d, gcnt_q, gcnt_d;
  logic [NUM_DESIGNS-1:0] ncs_q, ncs_d;
  logic req_valid;
  always_comb begin
    cnt_d     = (s2_q != cand_q) ? '0 : (cnt_q < STABLE) ? cnt_q + 8'd1 : cnt_q;
    req_valid = cnt_q == STABLE;
    req       = (32'(cand_q) > NUM_DESIGNS) ? '0 : cand_q;
  end
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    gcnt_d   = gcnt_q;
    active_d = active_q;
    case (state_q)
      IDLE: if (req_valid && req != '0) begin
        state_d  = GUARD;
        target_d = req;
        gcnt_d   = '0;
      end
      ACTIVE: if (req_valid && req != active_q) begin
        state_d  = GUARD;
        target_d = req;
        gcnt_d   = '0;
        active_d = '0;
      end
      GUARD: begin
        gcnt_d = gcnt_q + 8'd1;
        if (req_valid) target_d = req;
        if (gcnt_q == GLAST) begin
          state_d  = (target_q != '0) ? ACTIVE : IDLE;
          active_d = target_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // chip selects are registered from next state so they change on the same edge as the state
  always_comb begin
    for (int k = 0; k < NUM_DESIGNS; k++)
      ncs_d[k] = !(state_d == ACTIVE && active_d == SEL_WIDTH'(k + 1));
  end
  always_comb begin
    gpio_out = '0;
    gpio_oeb = '1;
    for (int k = 0; k < NUM_DESIGNS; k++)
      if (state_q == ACTIVE && active_q == SEL_WIDTH'(k + 1)) begin
        gpio_out = designs_gpio_out[k*GPIO_WIDTH +: GPIO_WIDTH];
        gpio_oeb = designs_gpio_oeb[k*GPIO_WIDTH +: GPIO_WIDTH];
      end
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      target_q <= '0;
      gcnt_q   <= '0;
      active_q <= '0;
      ncs_q    <= '1;
    end else begin
      s1_q     <= design_select;
      s2_q     <= s1_q;
      cand_q   <= s2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      target_q <= target_d;
      gcnt_q   <= gcnt_d;
      active_q <= active_d;
      ncs_q    <= ncs_d;
    end
  end
  assign designs_ncs   = ncs_q;
  assign active_design = active_q;
  assign switching     = state_q == GUARD;
endmodule

// File: tb/tb_design_switcher.sv
// tb_design_switcher: randomized and directed checks of design_switcher against a behavioural model.
module tb_design_switcher;
  localparam int ND = 12, GW = 34, SW = 4, ST = 4, GC = 8;
  logic clk = 1'b0, n_rst = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [ND*GW-1:0] gout, goeb;
  logic [GW-1:0] gpio_out, gpio_oeb;
  logic [ND-1:0] ncs;
  logic [SW-1:0] act;
  logic sw;
  logic [1:0] sel2 = 2'd3;
  logic [23:0] gout2, goeb2;
  logic [7:0] out2, oeb2;
  logic [2:0] ncs2;
  logic [1:0] act2;
  logic sw2;
  int errors = 0, checks = 0;
  int m_s1, m_s2, m_cand, m_run, m_mode, m_tgt, m_act, m_gleft, m_r;
  bit m_v, chk_en = 1'b0;
  logic [ND-1:0] e_ncs;
  logic [GW-1:0] e_out, e_oeb;

  design_switcher dut (
    .clk(clk), .n_rst(n_rst), .design_select(sel),
    .designs_gpio_out(gout), .designs_gpio_oeb(goeb),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb),
    .designs_ncs(ncs), .active_design(act), .switching(sw)
  );
  design_switcher #(.NUM_DESIGNS(3), .GPIO_WIDTH(8)) dut2 (
    .clk(clk), .n_rst(n_rst), .design_select(sel2),
    .designs_gpio_out(gout2), .designs_gpio_oeb(goeb2),
    .gpio_out(out2), .gpio_oeb(oeb2),
    .designs_ncs(ncs2), .active_design(act2), .switching(sw2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // mode: 0 none driving, 1 guard, 2 a design driving; gleft counts guard cycles still to go
  always @(posedge clk) begin
    if (!n_rst) begin
      m_s1 = 0; m_s2 = 0; m_cand = 0; m_run = 0;
      m_mode = 0; m_tgt = 0; m_act = 0; m_gleft = 0;
    end else begin
      m_v = m_run == ST;
      m_r = (m_cand > ND) ? 0 : m_cand;
      if (m_s2 != m_cand) begin
        m_cand = m_s2;
        m_run = 0;
      end else if (m_run < ST) m_run++;
      m_s2 = m_s1;
      m_s1 = int'(sel);
      case (m_mode)
        0: if (m_v && m_r != 0) begin m_mode = 1; m_tgt = m_r; m_gleft = GC; end
        2: if (m_v && m_r != m_act) begin m_mode = 1; m_tgt = m_r; m_act = 0; m_gleft = GC; end
        default: begin
          m_gleft--;
          if (m_gleft == 0) begin
            m_act = m_tgt;
            m_mode = (m_tgt != 0) ? 2 : 0;
          end else if (m_v) m_tgt = m_r;
        end
      endcase
    end
  end

  always @(negedge clk) if (chk_en) begin
    e_ncs = '1; e_out = '0; e_oeb = '1;
    if (m_mode == 2) begin
      e_ncs[m_act-1] = 1'b0;
      e_out = gout[(m_act-1)*GW +: GW];
      e_oeb = goeb[(m_act-1)*GW +: GW];
    end
    chk("ncs", 64'(ncs), 64'(e_ncs));
    chk("gpio_out", 64'(gpio_out), 64'(e_out));
    chk("gpio_oeb", 64'(gpio_oeb), 64'(e_oeb));
    chk("active_design", 64'(act), 64'(m_act));
    chk("switching", 64'(sw), 64'(m_mode == 1));
    chk("ncs_onecold", 64'($countones(~ncs) <= 1), 64'd1);
  end

  task automatic randomize_gpio();
    for (int k = 0; k < ND; k++) begin
      gout[k*GW +: GW] = 34'({$urandom(), $urandom()});
      goeb[k*GW +: GW] = 34'({$urandom(), $urandom()});
    end
  endtask

  initial begin
    int cnt;
    randomize_gpio();
    gout[2*GW +: GW] = 34'h2AAAAAAAA;
    goeb[2*GW +: GW] = '0;
    gout2 = 24'($urandom());
    goeb2 = 24'($urandom());
    gout2[16 +: 8] = 8'hA5;
    goeb2[16 +: 8] = 8'h0F;
    sel = 4'd3;
    edges(1);
    chk_en = 1'b1;
    edges(2);
    chk("rst_ncs", 64'(ncs), 64'hFFF);
    chk("rst_oeb", 64'(gpio_oeb), 64'h3FFFFFFFF);
    chk("rst_out", 64'(gpio_out), 64'h0);
    chk("rst_sw", 64'(sw), 64'h0);
    chk("rst_act", 64'(act), 64'h0);
    n_rst = 1'b1;
    edges(7);
    chk("pre_guard_sw", 64'(sw), 64'h0);
    edges(1);
    chk("guard_entry_sw", 64'(sw), 64'h1);
    edges(7);
    chk("guard_end_ncs", 64'(ncs), 64'hFFF);
    chk("guard_end_sw", 64'(sw), 64'h1);
    edges(1);
    chk("a3_ncs", 64'(ncs), 64'hFFB);
    chk("a3_out", 64'(gpio_out), 64'h2AAAAAAAA);
    chk("a3_oeb", 64'(gpio_oeb), 64'h0);
    chk("a3_act", 64'(act), 64'h3);
    chk("small_ncs", 64'(ncs2), 64'h3);
    chk("small_out", 64'(out2), 64'hA5);
    chk("small_oeb", 64'(oeb2), 64'h0F);
    chk("small_act", 64'(act2), 64'h3);
    sel = 4'd5;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin edges(1); cnt += int'(sw); end
    chk("guard_len", 64'(cnt), 64'd8);
    chk("a5_ncs", 64'(ncs), 64'hFEF);
    chk("a5_act", 64'(act), 64'h5);
    sel = 4'd7;
    edges(3);
    sel = 4'd5;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin edges(1); cnt += int'(sw); end
    chk("glitch_sw", 64'(cnt), 64'd0);
    chk("glitch_ncs", 64'(ncs), 64'hFEF);
    sel = 4'd15;
    edges(20);
    chk("oor_act", 64'(act), 64'h0);
    chk("oor_ncs", 64'(ncs), 64'hFFF);
    chk("oor_sw", 64'(sw), 64'h0);
    sel = 4'd2;
    edges(7);
    sel = 4'd9;
    edges(8);
    chk("retarget_sw", 64'(sw), 64'h1);
    edges(1);
    chk("retarget_act", 64'(act), 64'h9);
    chk("retarget_ncs", 64'(ncs), 64'hEFF);
    sel = 4'd4;
    edges(12);
    chk("midguard_sw", 64'(sw), 64'h1);
    n_rst = 1'b0;
    edges(1);
    chk("midrst_sw", 64'(sw), 64'h0);
    chk("midrst_ncs", 64'(ncs), 64'hFFF);
    chk("midrst_act", 64'(act), 64'h0);
    n_rst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      randomize_gpio();
      sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        n_rst = 1'b0;
        edges($urandom_range(1, 2));
        n_rst = 1'b1;
      end
      edges($urandom_range(1, 25));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/design_switcher.md
DESIGN_SWITCHER -- requirements
Module: design_switcher

Interface
REQ-001 Parameter NUM_DESIGNS, default 12: number of hosted designs, numbered 1..NUM_DESIGNS; select 0 means none.
REQ-002 Parameter GPIO_WIDTH, default 34: GPIO pad count.
REQ-003 Parameter STABLE_CYCLES, default 4: cycles a synchronised select must hold before acceptance; legal range 0..255.
REQ-004 Parameter GUARD_CYCLES, default 8: safe-state cycles between designs; legal range 1..255.
REQ-005 Parameter SEL_WIDTH, default $clog2(NUM_DESIGNS+1) (4): select width.
REQ-006 The block has one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  system clock; all state updates on rising edge.
REQ-008 n_rst  in  1  synchronous active-low reset.
REQ-009 design_select  in  SEL_WIDTH  requested design; asynchronous to clk.
REQ-010 designs_gpio_out  in  NUM_DESIGNS*GPIO_WIDTH  design k output in slice [(k-1)*GPIO_WIDTH +: GPIO_WIDTH].
REQ-011 designs_gpio_oeb  in  NUM_DESIGNS*GPIO_WIDTH  design k active-low output enables, same slicing.
REQ-012 gpio_out  out  GPIO_WIDTH  pad output values.
REQ-013 gpio_oeb  out  GPIO_WIDTH  pad output enables, active low.
REQ-014 designs_ncs  out  NUM_DESIGNS  active-low chip selects; bit k-1 belongs to design k; registered.
REQ-015 active_design  out  SEL_WIDTH  design currently driving pads; 0 = none; registered.
REQ-016 switching  out  1  high while in GUARD state.

Function
REQ-017 design_select SHALL pass through a two-flop synchroniser (s1, s2) before any use.
REQ-018 Filter: if s2 != cand then cand <= s2 and cnt <= 0; else if cnt < STABLE_CYCLES then cnt <= cnt+1.
REQ-019 req_valid SHALL equal (cnt == STABLE_CYCLES); req SHALL equal cand, forced to 0 when cand > NUM_DESIGNS.
REQ-020 FSM states: IDLE, GUARD, ACTIVE; registers target, gcnt, active_design.
REQ-021 IDLE: on req_valid and req != 0 -> GUARD, target <= req, gcnt <= 0.
REQ-022 ACTIVE: on req_valid and req != active_design -> GUARD, target <= req, gcnt <= 0, active_design <= 0.
REQ-023 GUARD: gcnt increments each cycle. target <= req whenever req_valid, without restarting gcnt.
REQ-024 GUARD exit: when gcnt == GUARD_CYCLES-1, go to ACTIVE with active_design <= target if target != 0, else go to IDLE.
REQ-025 designs_ncs SHALL be all ones except in ACTIVE, where only bit active_design-1 is 0.
REQ-026 In ACTIVE, gpio_out and gpio_oeb SHALL combinationally equal design active_design's slices (zero latency).
REQ-027 In IDLE and GUARD, gpio_out SHALL be all 0 and gpio_oeb all 1 (all pads inputs).
REQ-028 Latency: a select change first sampled at edge 1 SHALL enter GUARD at edge 4+STABLE_CYCLES and ACTIVE/IDLE at edge 4+STABLE_CYCLES+GUARD_CYCLES (16 with defaults).
REQ-029 A select glitch held fewer than STABLE_CYCLES+1 synchronised cycles SHALL cause no state change.
REQ-030 Request equal to current active_design, or 0 while IDLE, SHALL cause no transition.
REQ-031 Out-of-range select SHALL behave exactly as select 0.
REQ-032 No two bits of designs_ncs SHALL ever be 0 simultaneously; the GUARD state SHALL always separate two ACTIVE periods.

Reset
REQ-033 While n_rst is 0 at a rising edge: s1, s2, cand, cnt, target, gcnt and active_design SHALL be 0, and state SHALL be IDLE.
REQ-034 Consequently, during and after reset: designs_ncs SHALL be all ones, gpio_oeb all ones, gpio_out 0, switching 0.
REQ-035 Reset asserted in any state, including mid-GUARD, SHALL take effect at the next edge with no partial switch.

Verification
REQ-036 Reset release, select 3 held, design 3 drives out=0x2AAAAAAAA, oeb=0 -> ncs=0xFFB at edge 16, gpio_out=0x2AAAAAAAA, gpio_oeb=0, active_design=3.
REQ-037 From ACTIVE 3, select -> 5 -> switching=1 and outputs safe (out 0, oeb all 1, ncs 0xFFF) for exactly 8 cycles, then ncs=0xFEF and active_design=5.
REQ-038 From ACTIVE 5, select pulses to 7 for 3 cycles, then returns to 5 -> no change in ncs, switching stays 0.
REQ-039 From ACTIVE 5, select=15 (out of range) -> after GUARD, state IDLE, active_design=0, ncs=0xFFF.
REQ-040 During GUARD toward 2, select changes to 9 and is accepted -> GUARD exits at the original gcnt count with active_design=9.
REQ-041 n_rst asserted at gcnt=4 mid-GUARD -> next edge: IDLE, ncs=0xFFF, switching=0; NUM_DESIGNS=3, GPIO_WIDTH=8 instance passes REQ-036 equivalent.
